// File: rtl/watch_ctrl.sv
// Stopwatch sequencing core: run/pause FSM, tick prescaler,
// 32-bit elapsed-time counter and a ten-entry lap buffer.
module watch_ctrl #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic        iPCLK,
    input  logic        iPRESETn,
    input  logic        iWATCH_START,
    input  logic        iWATCH_STOP,
    input  logic        iWATCH_RESET,
    input  logic        iWATCH_STORE,
    output logic [31:0] oCURR_TIME,
    output logic [31:0] oTIME_LAP0,
    output logic [31:0] oTIME_LAP1,
    output logic [31:0] oTIME_LAP2,
    output logic [31:0] oTIME_LAP3,
    output logic [31:0] oTIME_LAP4,
    output logic [31:0] oTIME_LAP5,
    output logic [31:0] oTIME_LAP6,
    output logic [31:0] oTIME_LAP7,
    output logic [31:0] oTIME_LAP8,
    output logic [31:0] oTIME_LAP9,
    output logic [3:0]  oLAP_CNT,
    output logic        oLAP_FULL,
    output logic        oRUNNING
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] NLAP = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_prev_start;
    logic          r_prev_stop;
    logic          r_prev_rst;
    logic          r_prev_store;
    logic [PW-1:0] r_presc;
    logic [31:0]   r_curr_time;
    logic [31:0]   r_lap [10];
    logic [3:0]    r_lap_cnt;

    logic w_start;
    logic w_stop;
    logic w_rst;
    logic w_store;
    logic w_count;
    logic w_tick;
    logic w_store_ok;

    assign w_start = iWATCH_START & ~r_prev_start;
    assign w_stop  = iWATCH_STOP  & ~r_prev_stop;
    assign w_rst   = iWATCH_RESET & ~r_prev_rst;
    assign w_store = iWATCH_STORE & ~r_prev_store;

    // A stop edge freezes the prescaler so a resume continues the partial tick.
    assign w_count = (r_state == ST_RUN) & ~w_rst & ~w_stop;
    assign w_tick  = w_count & (r_presc == PMAX);

    assign w_store_ok = w_store & ~w_rst
                      & (r_state != ST_IDLE)
                      & (r_lap_cnt < NLAP);

    always_comb begin
        w_next = r_state;
        if (w_rst) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (w_start) w_next = ST_RUN;
                ST_RUN:   if (w_stop)  w_next = ST_PAUSE;
                ST_PAUSE: if (w_start) w_next = ST_RUN;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iPCLK or negedge iPRESETn) begin
        if (!iPRESETn) begin
            r_state      <= ST_IDLE;
            r_prev_start <= 1'b0;
            r_prev_stop  <= 1'b0;
            r_prev_rst   <= 1'b0;
            r_prev_store <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_prev_start <= iWATCH_START;
            r_prev_stop  <= iWATCH_STOP;
            r_prev_rst   <= iWATCH_RESET;
            r_prev_store <= iWATCH_STORE;
        end
    end

    always_ff @(posedge iPCLK or negedge iPRESETn) begin
        if (!iPRESETn) begin
            r_presc     <= '0;
            r_curr_time <= '0;
            r_lap_cnt   <= '0;
            for (int i = 0; i < 10; i++) r_lap[i] <= '0;
        end else if (w_rst) begin
            r_presc     <= '0;
            r_curr_time <= '0;
            r_lap_cnt   <= '0;
            for (int i = 0; i < 10; i++) r_lap[i] <= '0;
        end else begin
            if (w_tick) begin
                r_presc     <= '0;
                r_curr_time <= r_curr_time + 32'd1;
            end else if (w_count) begin
                r_presc <= r_presc + PW'(1);
            end
            // Lap captures the pre-edge time, before any same-edge increment.
            if (w_store_ok) begin
                r_lap_cnt <= r_lap_cnt + 4'd1;
                for (int i = 0; i < 10; i++) begin
                    if (r_lap_cnt == 4'(i)) r_lap[i] <= r_curr_time;
                end
            end
        end
    end

    assign oCURR_TIME = r_curr_time;
    assign oTIME_LAP0 = r_lap[0];
    assign oTIME_LAP1 = r_lap[1];
    assign oTIME_LAP2 = r_lap[2];
    assign oTIME_LAP3 = r_lap[3];
    assign oTIME_LAP4 = r_lap[4];
    assign oTIME_LAP5 = r_lap[5];
    assign oTIME_LAP6 = r_lap[6];
    assign oTIME_LAP7 = r_lap[7];
    assign oTIME_LAP8 = r_lap[8];
    assign oTIME_LAP9 = r_lap[9];
    assign oLAP_CNT   = r_lap_cnt;
    assign oLAP_FULL  = (r_lap_cnt == NLAP);
    assign oRUNNING   = (r_state == ST_RUN);

endmodule

// File: doc/watch_ctrl.md
# watch_ctrl

Stopwatch sequencing core behind the APB register interface. Consumes the single-cycle start/stop/reset/store command pulses from the APB block and runs the run/pause state machine, the tick prescaler and the 32-bit elapsed-time counter. Captures up to ten lap times into a lap buffer. Drives the current-time and lap-time values that the APB block returns on reads.

## Interface
- TICK_DIV, 100: iPCLK cycles per time unit. Legal range is 1..65535; prescaler width is $clog2(TICK_DIV), minimum 1 bit.
- iPCLK  in  1  single clock; all state changes on its rising edge
- iPRESETn  in  1  asynchronous, active-low reset
- iWATCH_START  in  1  start/resume command; rising-edge detected
- iWATCH_STOP  in  1  pause command; rising-edge detected
- iWATCH_RESET  in  1  clear command; rising-edge detected
- iWATCH_STORE  in  1  lap-capture command; rising-edge detected
- oCURR_TIME  out  32  elapsed time units
- oTIME_LAP0..oTIME_LAP9  out  32 each  captured laps, in capture order
- oLAP_CNT  out  4  number of laps stored, 0..10
- oLAP_FULL  out  1  high when oLAP_CNT == 10
- oRUNNING  out  1  high in RUN state

## Operation
- Edge detect:
  - One prev register per command input; rise = in & ~prev.
  - A level held high for many cycles counts as one command.
  - prev registers reset to 0, so an input already high when reset releases counts as a rise on the first edge.
- States: IDLE (reset state), RUN, PAUSE.
  - IDLE + start → RUN.
  - RUN + stop → PAUSE.
  - PAUSE + start → RUN.
  - Any state + reset → IDLE.
  - Start in RUN is ignored. Stop in IDLE or PAUSE is ignored.
- Command priority within one edge: reset > stop > start. Store is evaluated independently, but a reset on the same edge suppresses it.
- Reset command (and iPRESETn) clears:
  - oCURR_TIME, prescaler, all ten laps, oLAP_CNT, and state to IDLE.
  - iPRESETn additionally clears the prev registers.
- Prescaler:
  - Counts only in RUN, from 0 to TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1, it wraps to 0 and oCURR_TIME increments.
  - Holds its value in PAUSE, so a resumed run continues the partial tick.
  - Cleared when entering IDLE.
  - With TICK_DIV=1, oCURR_TIME increments on every RUN edge.
- oCURR_TIME arithmetic: unsigned 32-bit, wraps 0xFFFFFFFF → 0 with no flag.
- Store:
  - Accepted only in RUN or PAUSE with oLAP_CNT < 10.
  - Writes the pre-edge oCURR_TIME value (the value before any same-edge increment) into lap[oLAP_CNT], then oLAP_CNT increments.
  - Store in IDLE, or when full, is ignored. There is no wrap and no overwrite.
  - Store together with stop or start on the same edge: both take effect.
- Unused lap slots read 0.

## Timing
- Command latency: input high before edge k → state, lap and count updated at edge k; outputs are registered and visible after edge k.
- Start accepted at edge k from IDLE: oRUNNING = 1 after edge k; oCURR_TIME becomes 1 at edge k+TICK_DIV, then increments every TICK_DIV edges.
- Stop at edge k: no increment occurs at edge k or later, even if the prescaler was at TICK_DIV-1.
- iPRESETn assertion clears all outputs immediately, without waiting for a clock. Reset values: oCURR_TIME = 0, all laps = 0, oLAP_CNT = 0, oLAP_FULL = 0, oRUNNING = 0.
- Reset mid-run, by either pin or command, discards the partial prescaler count.
- Commands arriving one cycle apart are each processed, provided each has a rising edge.

## Test plan
- Basic run (TICK_DIV=4): pulse start, wait 40 cycles, pulse stop → oCURR_TIME = 10, oRUNNING = 0; value holds for the next 20 cycles.
- Pause/resume partial tick (TICK_DIV=4): start, stop 6 cycles later, wait 10 cycles, start, 2 cycles later → oCURR_TIME = 2; no lost or extra tick.
- Laps: in RUN, issue 11 stores at known times → oTIME_LAP0..9 hold increasing captured values; the 11th store is ignored; oLAP_CNT = 10 and oLAP_FULL = 1. A store in IDLE leaves oLAP_CNT = 0.
- Held level and priority:
  - Hold start high for 50 cycles → exactly one start.
  - Stop and start in the same cycle while in RUN → PAUSE.
  - Reset and store in the same cycle → all laps 0 and oLAP_CNT = 0.
- Wrap: force oCURR_TIME near 0xFFFFFFFE (via a bench backdoor), TICK_DIV=1, run 3 cycles → 0xFFFFFFFE → 0xFFFFFFFF → 0 → 1.
- Async reset mid-run: assert iPRESETn low between clock edges → all outputs 0 immediately. Release with iWATCH_START held high → RUN begins on the first edge.
